mem_rd_arbiter: RTL and testbench
=================================

# mem_rd_arbiter

Two-master, one-slave AXI-lite read-channel arbiter sharing the single memory read port between the instruction fetch unit (master 0, IFU) and the load/store unit (master 1, LSU). Sits between the IFU/LSU AR/R ports and the memory model. It enforces one outstanding read at a time and uses round-robin grant, so the IFU, whose ARVALID is permanently high, cannot starve loads.

## Interface
- ADDR_W, 32, read address width (`MemAddrBus`)
- DATA_W, 64, read data width (`MemDataBus`)
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- ifu_ARVALID  input  1  IFU read request
- ifu_ARADDR  input  ADDR_W  IFU read address
- ifu_ARREADY  output  1  address accepted, to IFU
- ifu_RVALID  output  1  read data valid, to IFU
- ifu_RDATA  output  DATA_W  read data, to IFU
- ifu_RREADY  input  1  IFU accepts data
- lsu_ARVALID, lsu_ARADDR, lsu_ARREADY, lsu_RVALID, lsu_RDATA, lsu_RREADY  same directions and widths as ifu_*, for LSU
- mem_ARVALID  output  1  request to memory
- mem_ARADDR  output  ADDR_W  address to memory
- mem_ARREADY  input  1  memory accepts address
- mem_RVALID  input  1  memory data valid
- mem_RDATA  input  DATA_W  memory data
- mem_RREADY  output  1  data accepted by granted master
- grant  output  1  current/last owner: 0 = IFU, 1 = LSU
- busy  output  1  high in ADDR or DATA state

## Operation
- FSM states: IDLE, ADDR, DATA. Registers: state, grant, last (last granted master).
- IDLE: if exactly one master has ARVALID, grant it. If both are asserted, grant !last. On the next edge go to ADDR with grant registered. If no request, stay in IDLE.
- ADDR: mem_ARVALID/mem_ARADDR are combinationally muxed from the granted master. mem_ARREADY is routed only to the granted master's ARREADY. When mem_ARVALID & mem_ARREADY, go to DATA.
- DATA: mem_RVALID drives only the granted master's RVALID. mem_RREADY = granted master's RREADY. When mem_RVALID & mem_RREADY, go to IDLE and set last <= grant.
- RDATA: mem_RDATA is broadcast to both masters. Only the granted master sees RVALID.
- Non-granted master: ARREADY=0 and RVALID=0 at all times. Its request is held pending; it is never dropped or reordered.
- A master deasserting ARVALID in ADDR before the handshake is a protocol violation. The arbiter stays in ADDR, keeps the grant, and mem_ARVALID follows the master.
- No address decode, no transformation of the data word. Half-word selection stays in the masters.

## Timing
- Reset values: state=IDLE, grant=0, last=1 (IFU wins the first contested cycle), busy=0, mem_ARVALID=0, mem_RREADY=0, ifu/lsu ARREADY=0, ifu/lsu RVALID=0. mem_ARADDR and RDATA outputs are don't-care while their valids are 0.
- Request in IDLE at cycle N → mem_ARVALID high in cycle N+1.
- AR handshake at cycle M → DATA from M+1. R handshake at cycle K → IDLE at K+1. The next grant is visible at K+2.
- Minimum 3 cycles per transaction with zero-wait memory. Back-to-back contested requests alternate IFU, LSU, IFU, ...
- Memory returning RVALID in the same cycle as the AR handshake is not supported. R is sampled only in DATA.
- rst asserted in any state returns the FSM to IDLE on that edge and drops all outputs to their reset values. Any in-flight memory transaction is abandoned; the memory model is reset with the arbiter.
- rst has priority over all handshakes in the same cycle.

## Test plan
- Single IFU fetch: ifu_ARVALID=1, addr 0x80000000, LSU idle, memory returns 0x00000013_00100093 one cycle after AR → IFU gets RVALID with that data. lsu_RVALID stays 0. grant=0 throughout.
- Contention after reset: both ARVALID=1 from cycle 0 → grants in order IFU, LSU, IFU, LSU over 4 transactions. mem_ARADDR alternates 0x80000000 / 0x80001000.
- LSU anti-starvation: IFU ARVALID constantly 1, LSU raises request to 0x80002008 while an IFU read is in DATA → the LSU is granted right after that IFU transaction completes (at most one IFU transaction in between).
- Backpressure: mem_ARREADY low for 3 cycles, then mem_RVALID held while lsu_RREADY low for 2 cycles → state holds ADDR and then DATA. mem_RREADY mirrors lsu_RREADY. Exactly one completed transfer.
- Reset mid-transaction: rst pulsed in DATA state → next cycle state=IDLE, busy=0, all valids 0, grant=0. The next contested request goes to IFU.
- Idle: no ARVALID for 10 cycles → mem_ARVALID=0 and busy=0 throughout.

Source files
------------

// File: rtl/mem_rd_arbiter_if.sv
// AXI-lite read channel (AR + R) bundle shared by the IFU, LSU and memory ports.
//   master modport: drives ARVALID/ARADDR/RREADY, receives ARREADY/RVALID/RDATA
//   slave  modport: the opposite direction of every signal
interface mem_rd_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic              ARVALID;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARREADY;
    logic              RVALID;
    logic [DATA_W-1:0] RDATA;
    logic              RREADY;

    modport master (
        output ARVALID, ARADDR, RREADY,
        input  ARREADY, RVALID, RDATA
    );

    modport slave (
        input  ARVALID, ARADDR, RREADY,
        output ARREADY, RVALID, RDATA
    );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Two-master round-robin read arbiter: IFU (master 0) and LSU (master 1) share
// one memory read port with a single outstanding read at a time.
//   clk, rst : clock, synchronous active-high reset
//   ifu, lsu : slave-side read channels from the two masters
//   mem      : master-side read channel to the memory
//   grant    : current/last owner (0 = IFU, 1 = LSU)
//   busy     : a transaction is in its address or data phase
module mem_rd_arbiter (
    input  logic             clk,
    input  logic             rst,
    mem_rd_arbiter_if.slave  ifu,
    mem_rd_arbiter_if.slave  lsu,
    mem_rd_arbiter_if.master mem,
    output logic             grant,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_q,  last_d;
    logic   sel_arvalid;
    logic   sel_rready;

    // State registers; last resets to LSU so the IFU wins the first contest.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic and channel routing toward the granted master.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        sel_arvalid = grant_q ? lsu.ARVALID : ifu.ARVALID;
        sel_rready  = grant_q ? lsu.RREADY  : ifu.RREADY;

        mem.ARVALID = 1'b0;
        mem.ARADDR  = grant_q ? lsu.ARADDR : ifu.ARADDR;
        mem.RREADY  = 1'b0;
        ifu.ARREADY = 1'b0;
        lsu.ARREADY = 1'b0;
        ifu.RVALID  = 1'b0;
        lsu.RVALID  = 1'b0;
        // Data is broadcast; only the owner ever sees RVALID.
        ifu.RDATA   = mem.RDATA;
        lsu.RDATA   = mem.RDATA;

        case (state_q)
            ST_IDLE: begin
                if (ifu.ARVALID || lsu.ARVALID) begin
                    state_d = ST_ADDR;
                    // Contested: alternate away from the previous owner.
                    if (ifu.ARVALID && lsu.ARVALID) begin
                        grant_d = ~last_q;
                    end else begin
                        grant_d = lsu.ARVALID;
                    end
                end
            end
            ST_ADDR: begin
                // Grant is held even if the owner drops ARVALID early.
                mem.ARVALID = sel_arvalid;
                if (grant_q) begin
                    lsu.ARREADY = mem.ARREADY;
                end else begin
                    ifu.ARREADY = mem.ARREADY;
                end
                if (sel_arvalid && mem.ARREADY) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                mem.RREADY = sel_rready;
                if (grant_q) begin
                    lsu.RVALID = mem.RVALID;
                end else begin
                    ifu.RVALID = mem.RVALID;
                end
                if (mem.RVALID && sel_rready) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant = grant_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: inputs driven and outputs sampled at the
// falling edge, expected values written by hand in each step.
module tb_mem_rd_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic grant;
    logic busy;
    int   errors = 0;
    int   checks = 0;
    int   xfers;

    mem_rd_arbiter_if #(.ADDR_W(32), .DATA_W(64)) ifu_bus ();
    mem_rd_arbiter_if #(.ADDR_W(32), .DATA_W(64)) lsu_bus ();
    mem_rd_arbiter_if #(.ADDR_W(32), .DATA_W(64)) mem_bus ();

    mem_rd_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .ifu   (ifu_bus),
        .lsu   (lsu_bus),
        .mem   (mem_bus),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ifu_bus.ARVALID = 1'b0;
        ifu_bus.ARADDR  = 32'h0;
        ifu_bus.RREADY  = 1'b0;
        lsu_bus.ARVALID = 1'b0;
        lsu_bus.ARADDR  = 32'h0;
        lsu_bus.RREADY  = 1'b0;
        mem_bus.ARREADY = 1'b0;
        mem_bus.RVALID  = 1'b0;
        mem_bus.RDATA   = 64'h0;
    endtask

    // One reset edge; returns at the falling edge of the first IDLE cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for the address phase, checks routing, then completes R with zero wait.
    task automatic txn(input logic exp_g, input logic [31:0] exp_addr,
                       input logic [63:0] data, input bit raise_lsu);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            mem_bus.RVALID = 1'b0;
            #1;
            found = mem_bus.ARVALID;
        end
        chk_b("txn_ar_seen", found, 1'b1);
        if (found) begin
            chk_b("txn_grant", grant, exp_g);
            chk_w("txn_araddr", 64'(mem_bus.ARADDR), 64'(exp_addr));
            chk_b("txn_arready_own", exp_g ? lsu_bus.ARREADY : ifu_bus.ARREADY, 1'b1);
            chk_b("txn_arready_other", exp_g ? ifu_bus.ARREADY : lsu_bus.ARREADY, 1'b0);
            @(negedge clk);
            mem_bus.RVALID = 1'b1;
            mem_bus.RDATA  = data;
            ifu_bus.RREADY = 1'b1;
            lsu_bus.RREADY = 1'b1;
            if (raise_lsu) begin
                lsu_bus.ARVALID = 1'b1;
                lsu_bus.ARADDR  = 32'h8000_2008;
            end
            #1;
            chk_b("txn_rvalid_own", exp_g ? lsu_bus.RVALID : ifu_bus.RVALID, 1'b1);
            chk_b("txn_rvalid_other", exp_g ? ifu_bus.RVALID : lsu_bus.RVALID, 1'b0);
            chk_w("txn_rdata", exp_g ? lsu_bus.RDATA : ifu_bus.RDATA, data);
            chk_b("txn_mem_rready", mem_bus.RREADY, 1'b1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with hostile memory inputs: every output must still be quiet.
        rst = 1'b1;
        clear_inputs();
        mem_bus.ARREADY = 1'b1;
        mem_bus.RVALID  = 1'b1;
        ifu_bus.RREADY  = 1'b1;
        lsu_bus.RREADY  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_grant", grant, 1'b0);
        chk_b("rst_mem_arvalid", mem_bus.ARVALID, 1'b0);
        chk_b("rst_mem_rready", mem_bus.RREADY, 1'b0);
        chk_b("rst_ifu_arready", ifu_bus.ARREADY, 1'b0);
        chk_b("rst_lsu_arready", lsu_bus.ARREADY, 1'b0);
        chk_b("rst_ifu_rvalid", ifu_bus.RVALID, 1'b0);
        chk_b("rst_lsu_rvalid", lsu_bus.RVALID, 1'b0);
        rst = 1'b0;
        clear_inputs();

        // Single IFU fetch.
        @(negedge clk);
        ifu_bus.ARVALID = 1'b1;
        ifu_bus.ARADDR  = 32'h8000_0000;
        mem_bus.ARREADY = 1'b1;
        #1;
        chk_b("f_idle_busy", busy, 1'b0);
        chk_b("f_idle_arvalid", mem_bus.ARVALID, 1'b0);
        @(negedge clk);
        #1;
        chk_b("f_addr_busy", busy, 1'b1);
        chk_b("f_addr_grant", grant, 1'b0);
        chk_b("f_addr_arvalid", mem_bus.ARVALID, 1'b1);
        chk_w("f_addr_araddr", 64'(mem_bus.ARADDR), 64'h8000_0000);
        chk_b("f_addr_ifu_arready", ifu_bus.ARREADY, 1'b1);
        chk_b("f_addr_lsu_arready", lsu_bus.ARREADY, 1'b0);
        @(negedge clk);
        ifu_bus.ARVALID = 1'b0;
        mem_bus.ARREADY = 1'b0;
        mem_bus.RVALID  = 1'b1;
        mem_bus.RDATA   = 64'h0000_0013_0010_0093;
        ifu_bus.RREADY  = 1'b1;
        lsu_bus.RREADY  = 1'b1;
        #1;
        chk_b("f_data_ifu_rvalid", ifu_bus.RVALID, 1'b1);
        chk_w("f_data_ifu_rdata", ifu_bus.RDATA, 64'h0000_0013_0010_0093);
        chk_b("f_data_lsu_rvalid", lsu_bus.RVALID, 1'b0);
        chk_b("f_data_mem_rready", mem_bus.RREADY, 1'b1);
        chk_b("f_data_grant", grant, 1'b0);
        chk_b("f_data_arvalid", mem_bus.ARVALID, 1'b0);
        @(negedge clk);
        mem_bus.RVALID = 1'b0;
        #1;
        chk_b("f_end_busy", busy, 1'b0);
        chk_b("f_end_ifu_rvalid", ifu_bus.RVALID, 1'b0);
        chk_b("f_end_grant", grant, 1'b0);

        // Contention from the first cycle after reset: IFU, LSU, IFU, LSU.
        do_reset();
        ifu_bus.ARVALID = 1'b1;
        ifu_bus.ARADDR  = 32'h8000_0000;
        lsu_bus.ARVALID = 1'b1;
        lsu_bus.ARADDR  = 32'h8000_1000;
        mem_bus.ARREADY = 1'b1;
        txn(1'b0, 32'h8000_0000, 64'h1111_0000_0000_0001, 1'b0);
        txn(1'b1, 32'h8000_1000, 64'h2222_0000_0000_0002, 1'b0);
        txn(1'b0, 32'h8000_0000, 64'h3333_0000_0000_0003, 1'b0);
        txn(1'b1, 32'h8000_1000, 64'h4444_0000_0000_0004, 1'b0);

        // LSU request raised while an IFU read is in its data phase.
        lsu_bus.ARVALID = 1'b0;
        txn(1'b0, 32'h8000_0000, 64'h5555_0000_0000_0005, 1'b1);
        txn(1'b1, 32'h8000_2008, 64'h6666_0000_0000_0006, 1'b0);

        // Backpressure on AR then R, with an early ARVALID drop in ADDR.
        do_reset();
        xfers = 0;
        lsu_bus.ARVALID = 1'b1;
        lsu_bus.ARADDR  = 32'h8000_3000;
        #1;
        chk_b("bp_idle_busy", busy, 1'b0);
        @(negedge clk);
        #1;
        chk_b("bp_a1_arvalid", mem_bus.ARVALID, 1'b1);
        chk_b("bp_a1_grant", grant, 1'b1);
        chk_w("bp_a1_araddr", 64'(mem_bus.ARADDR), 64'h8000_3000);
        chk_b("bp_a1_lsu_arready", lsu_bus.ARREADY, 1'b0);
        @(negedge clk);
        lsu_bus.ARVALID = 1'b0;
        #1;
        chk_b("bp_a2_arvalid_follows", mem_bus.ARVALID, 1'b0);
        chk_b("bp_a2_busy", busy, 1'b1);
        chk_b("bp_a2_grant", grant, 1'b1);
        @(negedge clk);
        lsu_bus.ARVALID = 1'b1;
        #1;
        chk_b("bp_a3_arvalid", mem_bus.ARVALID, 1'b1);
        chk_b("bp_a3_busy", busy, 1'b1);
        @(negedge clk);
        mem_bus.ARREADY = 1'b1;
        #1;
        chk_b("bp_a4_lsu_arready", lsu_bus.ARREADY, 1'b1);
        chk_b("bp_a4_ifu_arready", ifu_bus.ARREADY, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            lsu_bus.ARVALID = 1'b0;
            mem_bus.ARREADY = 1'b0;
            mem_bus.RVALID  = 1'b1;
            mem_bus.RDATA   = 64'hDEAD_BEEF_0000_0007;
            lsu_bus.RREADY  = (c == 2);
            #1;
            chk_b("bp_d_lsu_rvalid", lsu_bus.RVALID, 1'b1);
            chk_b("bp_d_mem_rready", mem_bus.RREADY, (c == 2));
            chk_b("bp_d_busy", busy, 1'b1);
            if (lsu_bus.RVALID && lsu_bus.RREADY) xfers++;
        end
        chk_w("bp_d_rdata", lsu_bus.RDATA, 64'hDEAD_BEEF_0000_0007);
        @(negedge clk);
        #1;
        chk_b("bp_end_busy", busy, 1'b0);
        chk_b("bp_end_lsu_rvalid", lsu_bus.RVALID, 1'b0);
        if (lsu_bus.RVALID && lsu_bus.RREADY) xfers++;
        chk_w("bp_xfers", 64'(xfers), 64'd1);
        mem_bus.RVALID = 1'b0;

        // Reset in DATA after an IFU read: arbitration history must restart.
        ifu_bus.ARVALID = 1'b1;
        ifu_bus.ARADDR  = 32'h8000_0000;
        lsu_bus.ARVALID = 1'b0;
        mem_bus.ARREADY = 1'b1;
        txn(1'b0, 32'h8000_0000, 64'h7777_0000_0000_0008, 1'b0);
        ifu_bus.ARVALID = 1'b0;
        lsu_bus.ARVALID = 1'b1;
        lsu_bus.ARADDR  = 32'h8000_4000;
        @(negedge clk);
        mem_bus.RVALID = 1'b0;
        @(negedge clk);
        #1;
        chk_b("rm_addr_grant", grant, 1'b1);
        @(negedge clk);
        rst             = 1'b1;
        mem_bus.RVALID  = 1'b1;
        lsu_bus.RREADY  = 1'b1;
        #1;
        chk_b("rm_data_busy", busy, 1'b1);
        chk_b("rm_data_lsu_rvalid", lsu_bus.RVALID, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_b("rm_post_busy", busy, 1'b0);
        chk_b("rm_post_grant", grant, 1'b0);
        chk_b("rm_post_mem_arvalid", mem_bus.ARVALID, 1'b0);
        chk_b("rm_post_mem_rready", mem_bus.RREADY, 1'b0);
        chk_b("rm_post_lsu_rvalid", lsu_bus.RVALID, 1'b0);
        chk_b("rm_post_ifu_rvalid", ifu_bus.RVALID, 1'b0);
        ifu_bus.ARVALID = 1'b1;
        mem_bus.RVALID  = 1'b0;
        @(negedge clk);
        #1;
        chk_b("rm_next_grant", grant, 1'b0);
        chk_w("rm_next_araddr", 64'(mem_bus.ARADDR), 64'h8000_0000);

        // Idle: nothing requested for 10 cycles.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            chk_b("idle_arvalid", mem_bus.ARVALID, 1'b0);
            chk_b("idle_busy", busy, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
